// File: rtl/collision_pkg.sv
// Shared game definitions: state codes, evaluation FSM states, default geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package collision_pkg;

   // Game-level state codes driven by the game controller
   typedef enum logic [2:0] {
      GS_MAIN_MENU  = 3'd0,
      GS_LEVEL1     = 3'd1,
      GS_END_SCREEN = 3'd2
   } game_state_t;

   // Collision evaluation sequencer
   typedef enum logic [1:0] {
      FSM_IDLE    = 2'd0,
      FSM_PROBE   = 2'd1,
      FSM_RESOLVE = 2'd2
   } coll_fsm_t;

   // Default playfield and object geometry
   localparam int DEF_SCREEN_W = 160;
   localparam int DEF_SCREEN_H = 120;
   localparam int DEF_BRICK_W  = 20;
   localparam int DEF_BRICK_H  = 8;
   localparam int DEF_BRICK_TOP = 8;
   localparam int DEF_PADDLE_Y = 110;
   localparam int DEF_PADDLE_W = 24;

   // Brick grid shape: 4 rows x 8 columns, bit index = row*8 + col
   localparam int BRICK_ROWS = 4;
   localparam int BRICK_COLS = 8;
   localparam logic [31:0] BRICKS_ALL = 32'hFFFF_FFFF;

endpackage

// File: rtl/collision_unit_brick_locate.sv
// Maps a 9-bit probe coordinate to a brick index and an in-grid flag.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module brick_locate
   import collision_pkg::*;
#(
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int BRICK_W   = DEF_BRICK_W,
   parameter int BRICK_H   = DEF_BRICK_H,
   parameter int BRICK_TOP = DEF_BRICK_TOP
) (
   input  logic [8:0] i_x,
   input  logic [8:0] i_y,
   output logic       o_hit,
   output logic [4:0] o_idx
);

   logic [2:0] w_col;
   logic [1:0] w_row;
   logic [8:0] w_yOff;

   // Column/row found by counting crossed boundaries; avoids a divider.
   // Coordinates are 9 bits so that wrapped probes (511, 256) stay out of the grid.
   always_comb begin
      w_col  = 3'd0;
      w_row  = 2'd0;
      w_yOff = i_y - 9'(BRICK_TOP);
      for (int k = 1; k < BRICK_COLS; k++) begin
         if (i_x >= 9'(k * BRICK_W)) w_col = w_col + 3'd1;
      end
      for (int k = 1; k < BRICK_ROWS; k++) begin
         if (w_yOff >= 9'(k * BRICK_H)) w_row = w_row + 2'd1;
      end
      o_hit = (i_x < 9'(SCREEN_W)) &&
              (i_x < 9'(BRICK_COLS * BRICK_W)) &&
              (i_y >= 9'(BRICK_TOP)) &&
              (i_y < 9'(BRICK_TOP + BRICK_ROWS * BRICK_H));
      o_idx = {w_row, w_col};
   end

endmodule

// File: rtl/collision_unit.sv
// Evaluates ball collisions against walls, paddle and a 4x8 brick map per tick.
// Latency: flags and valid pulse for one cycle, 2 cycles after tick.
// Backpressure: none; ticks arriving while an evaluation is in flight are dropped.
module collision_unit
   import collision_pkg::*;
#(
   parameter int SCREEN_W  = DEF_SCREEN_W,
   parameter int SCREEN_H  = DEF_SCREEN_H,
   parameter int BRICK_W   = DEF_BRICK_W,
   parameter int BRICK_H   = DEF_BRICK_H,
   parameter int BRICK_TOP = DEF_BRICK_TOP,
   parameter int PADDLE_Y  = DEF_PADDLE_Y,
   parameter int PADDLE_W  = DEF_PADDLE_W
) (
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic [2:0]  i_state,
   input  logic        i_tick,
   input  logic [7:0]  i_ballX,
   input  logic [7:0]  i_ballY,
   input  logic        i_dirX,
   input  logic        i_dirY,
   input  logic [7:0]  i_paddleX,
   output logic        o_cX,
   output logic        o_cY,
   output logic        o_cBrickX,
   output logic        o_cBrickY,
   output logic        o_valid,
   output logic [31:0] o_brickMap,
   output logic [7:0]  o_score,
   output logic        o_lifeLost,
   output logic        o_cleared
);

   coll_fsm_t   r_fsm;
   logic [7:0]  r_ballX, r_ballY, r_paddleX;
   logic        r_dirX, r_dirY;
   logic [8:0]  r_pX, r_pY;
   logic [31:0] r_brickMap;
   logic [7:0]  r_score;
   logic        r_cX, r_cY, r_cBrickX, r_cBrickY, r_lifeLost, r_valid;

   logic        w_vLocHit, w_hLocHit;
   logic [4:0]  w_vIdx, w_hIdx;
   logic        w_vHit, w_hHit;
   logic [31:0] w_clearMask;
   logic        w_cX, w_cY, w_lifeLost, w_onPaddle;

   // Vertical probe: ball column, next row. Horizontal probe: next column, ball row.
   brick_locate #(
      .SCREEN_W (SCREEN_W), .BRICK_W (BRICK_W),
      .BRICK_H  (BRICK_H),  .BRICK_TOP (BRICK_TOP)
   ) u_locate_v (
      .i_x   ({1'b0, r_ballX}),
      .i_y   (r_pY),
      .o_hit (w_vLocHit),
      .o_idx (w_vIdx)
   );

   brick_locate #(
      .SCREEN_W (SCREEN_W), .BRICK_W (BRICK_W),
      .BRICK_H  (BRICK_H),  .BRICK_TOP (BRICK_TOP)
   ) u_locate_h (
      .i_x   (r_pX),
      .i_y   ({1'b0, r_ballY}),
      .o_hit (w_hLocHit),
      .o_idx (w_hIdx)
   );

   // Collision decisions from the captured snapshot; vertical brick hit wins over horizontal
   always_comb begin
      w_vHit      = w_vLocHit && r_brickMap[w_vIdx];
      w_hHit      = !w_vHit && w_hLocHit && r_brickMap[w_hIdx];
      w_clearMask = 32'd0;
      if (w_vHit)      w_clearMask[w_vIdx] = 1'b1;
      else if (w_hHit) w_clearMask[w_hIdx] = 1'b1;

      w_cX = (r_dirX && (r_ballX == 8'd0)) ||
             (!r_dirX && ({1'b0, r_ballX} == 9'(SCREEN_W - 1)));

      w_lifeLost = !r_dirY && ({1'b0, r_ballY} == 9'(SCREEN_H - 1));

      w_onPaddle = ({1'b0, r_ballY} + 9'd1 == 9'(PADDLE_Y)) &&
                   ({1'b0, r_paddleX} <= {1'b0, r_ballX}) &&
                   ({1'b0, r_ballX} <= {1'b0, r_paddleX} + 9'(PADDLE_W - 1));

      w_cY = !w_lifeLost &&
             ((r_dirY && (r_ballY == 8'd0)) || (!r_dirY && w_onPaddle));
   end

   // Sequencer: snapshot on tick, resolve and update map/score, pulse flags for one cycle
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_fsm      <= FSM_IDLE;
         r_ballX    <= 8'd0;
         r_ballY    <= 8'd0;
         r_paddleX  <= 8'd0;
         r_dirX     <= 1'b0;
         r_dirY     <= 1'b0;
         r_pX       <= 9'd0;
         r_pY       <= 9'd0;
         r_brickMap <= BRICKS_ALL;
         r_score    <= 8'd0;
         r_cX       <= 1'b0;
         r_cY       <= 1'b0;
         r_cBrickX  <= 1'b0;
         r_cBrickY  <= 1'b0;
         r_lifeLost <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_cX       <= 1'b0;
         r_cY       <= 1'b0;
         r_cBrickX  <= 1'b0;
         r_cBrickY  <= 1'b0;
         r_lifeLost <= 1'b0;
         r_valid    <= 1'b0;
         case (i_state)
            GS_MAIN_MENU: begin
               r_fsm      <= FSM_IDLE;
               r_brickMap <= BRICKS_ALL;
               r_score    <= 8'd0;
            end
            GS_LEVEL1: begin
               case (r_fsm)
                  FSM_IDLE: begin
                     if (i_tick) begin
                        r_ballX   <= i_ballX;
                        r_ballY   <= i_ballY;
                        r_paddleX <= i_paddleX;
                        r_dirX    <= i_dirX;
                        r_dirY    <= i_dirY;
                        r_pX      <= i_dirX ? ({1'b0, i_ballX} - 9'd1) : ({1'b0, i_ballX} + 9'd1);
                        r_pY      <= i_dirY ? ({1'b0, i_ballY} - 9'd1) : ({1'b0, i_ballY} + 9'd1);
                        r_fsm     <= FSM_PROBE;
                     end
                  end
                  FSM_PROBE: begin
                     r_cX       <= w_cX;
                     r_cY       <= w_cY;
                     r_cBrickX  <= w_hHit;
                     r_cBrickY  <= w_vHit;
                     r_lifeLost <= w_lifeLost;
                     r_valid    <= 1'b1;
                     r_brickMap <= r_brickMap & ~w_clearMask;
                     if ((w_vHit || w_hHit) && (r_score != 8'hFF))
                        r_score <= r_score + 8'd1;
                     r_fsm      <= FSM_RESOLVE;
                  end
                  default: r_fsm <= FSM_IDLE;
               endcase
            end
            default: r_fsm <= FSM_IDLE;
         endcase
      end
   end

   assign o_cX       = r_cX;
   assign o_cY       = r_cY;
   assign o_cBrickX  = r_cBrickX;
   assign o_cBrickY  = r_cBrickY;
   assign o_lifeLost = r_lifeLost;
   assign o_valid    = r_valid;
   assign o_brickMap = r_brickMap;
   assign o_score    = r_score;
   assign o_cleared  = (r_brickMap == 32'd0);

endmodule

// File: tb/tb_collision_unit.sv
// Directed bench for collision_unit with an expected-result queue.
// Latency: expects each evaluation result 2 cycles after tick.
// Backpressure: n/a.
module tb_collision_unit;
   import collision_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  st;
   logic        tick;
   logic [7:0]  bx, by, px;
   logic        dx, dy;
   logic        o_cX, o_cY, o_cBrickX, o_cBrickY, o_valid, o_lifeLost, o_cleared;
   logic [31:0] o_brickMap;
   logic [7:0]  o_score;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [4:0]  fl;     // {cX, cY, cBrickX, cBrickY, lifeLost}
      logic [31:0] map;
      logic [7:0]  score;
      logic        clr;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_map;
   logic [7:0]  m_score;

   always #5 clk = ~clk;

   collision_unit dut (
      .i_clock   (clk),
      .i_reset_n (rst_n),
      .i_state   (st),
      .i_tick    (tick),
      .i_ballX   (bx),
      .i_ballY   (by),
      .i_dirX    (dx),
      .i_dirY    (dy),
      .i_paddleX (px),
      .o_cX      (o_cX),
      .o_cY      (o_cY),
      .o_cBrickX (o_cBrickX),
      .o_cBrickY (o_cBrickY),
      .o_valid   (o_valid),
      .o_brickMap(o_brickMap),
      .o_score   (o_score),
      .o_lifeLost(o_lifeLost),
      .o_cleared (o_cleared)
   );

   // Monitor: each valid pulse consumes one expectation; flags must be quiet otherwise
   always @(negedge clk) begin
      exp_t e;
      logic [4:0] fl;
      fl = {o_cX, o_cY, o_cBrickX, o_cBrickY, o_lifeLost};
      if (o_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL unexpected_valid observed=1 expected=0 at %0t", $time);
         end else begin
            e = sb.pop_front();
            checks++;
            assert (fl === e.fl) else begin
               failures++;
               $error("FAIL flags observed=%b expected=%b", fl, e.fl);
            end
            checks++;
            assert (o_brickMap === e.map) else begin
               failures++;
               $error("FAIL map observed=%h expected=%h", o_brickMap, e.map);
            end
            checks++;
            assert (o_score === e.score) else begin
               failures++;
               $error("FAIL score observed=%0d expected=%0d", o_score, e.score);
            end
            checks++;
            assert (o_cleared === e.clr) else begin
               failures++;
               $error("FAIL cleared observed=%b expected=%b", o_cleared, e.clr);
            end
         end
      end else begin
         checks++;
         assert (fl === 5'b0) else begin
            failures++;
            $error("FAIL idle_flags observed=%b expected=00000", fl);
         end
      end
   end

   // One evaluation: drive ball, pulse tick, queue the expected outcome if one is due
   task automatic run_eval(input logic [7:0] x, input logic [7:0] y,
                           input logic ddx, input logic ddy,
                           input logic [4:0] fl, input int clr_bit,
                           input bit exp_valid);
      exp_t e;
      @(negedge clk);
      bx = x; by = y; dx = ddx; dy = ddy;
      tick = 1'b1;
      if (exp_valid) begin
         if (clr_bit >= 0) begin
            m_map[clr_bit] = 1'b0;
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
         end
         e.fl = fl; e.map = m_map; e.score = m_score; e.clr = (m_map == 32'd0);
         sb.push_back(e);
      end
      @(negedge clk);
      tick = 1'b0;
      for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL result_timeout pending=%0d expected=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_state(input string tag);
      checks++;
      assert (o_brickMap === m_map) else begin
         failures++;
         $error("FAIL %s_map observed=%h expected=%h", tag, o_brickMap, m_map);
      end
      checks++;
      assert (o_score === m_score) else begin
         failures++;
         $error("FAIL %s_score observed=%0d expected=%0d", tag, o_score, m_score);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst_n = 1'b0; st = GS_MAIN_MENU; tick = 1'b0;
      bx = 8'd0; by = 8'd0; dx = 1'b0; dy = 1'b0; px = 8'd50;
      m_map = 32'hFFFF_FFFF; m_score = 8'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_state("reset");
      checks++;
      assert (o_cleared === 1'b0 && o_valid === 1'b0) else begin
         failures++;
         $error("FAIL reset_status observed=%b%b expected=00", o_cleared, o_valid);
      end

      st = GS_LEVEL1;
      // Left wall
      run_eval(8'd0,   8'd60,  1'b1, 1'b0, 5'b10000, -1, 1'b1);
      // Vertical brick hit: probe (30,39) -> row 3 col 1 -> bit 25
      run_eval(8'd30,  8'd40,  1'b0, 1'b1, 5'b00010, 25, 1'b1);
      // Paddle 50..73: right edge bounces, one past does not, bottom loses life
      run_eval(8'd73,  8'd109, 1'b0, 1'b0, 5'b01000, -1, 1'b1);
      run_eval(8'd74,  8'd109, 1'b0, 1'b0, 5'b00000, -1, 1'b1);
      run_eval(8'd60,  8'd119, 1'b0, 1'b0, 5'b00001, -1, 1'b1);
      // Vertical probe on dead bit 25, horizontal probe (40,35) hits bit 26
      run_eval(8'd39,  8'd35,  1'b0, 1'b0, 5'b00100, 26, 1'b1);
      // Right wall; horizontal probe x=160 must miss
      run_eval(8'd159, 8'd39,  1'b0, 1'b0, 5'b10000, -1, 1'b1);
      // Left wall; horizontal probe underflows and must miss
      run_eval(8'd0,   8'd39,  1'b1, 1'b0, 5'b10000, -1, 1'b1);
      // Top-left corner, both probes underflow
      run_eval(8'd0,   8'd0,   1'b1, 1'b1, 5'b11000, -1, 1'b1);
      // Wall and brick together: vertical probe (0,21) -> bit 8
      run_eval(8'd0,   8'd20,  1'b1, 1'b0, 5'b10010, 8, 1'b1);

      // Tick held for two cycles: second one lands in PROBE and is dropped
      @(negedge clk);
      bx = 8'd100; by = 8'd100; dx = 1'b0; dy = 1'b0; tick = 1'b1;
      sb.push_back('{fl: 5'b0, map: m_map, score: m_score, clr: 1'b0});
      repeat (2) @(negedge clk);
      tick = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      assert (sb.size() == 0) else begin
         failures++;
         $error("FAIL double_tick pending=%0d expected=0", sb.size());
         sb.delete();
      end

      // End screen: tick ignored, map and score held
      st = GS_END_SCREEN;
      run_eval(8'd10,  8'd13,  1'b0, 1'b1, 5'b0, -1, 1'b0);
      check_state("endscreen");

      // Reset while in PROBE aborts the hit on bit 0
      st = GS_LEVEL1;
      @(negedge clk);
      bx = 8'd10; by = 8'd13; dx = 1'b0; dy = 1'b1; tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_map = 32'hFFFF_FFFF; m_score = 8'd0;
      repeat (5) @(negedge clk);
      check_state("abort");

      // Main menu reloads bricks and zeroes score; tick ignored
      run_eval(8'd10,  8'd13,  1'b0, 1'b1, 5'b00010, 0, 1'b1);
      st = GS_MAIN_MENU;
      m_map = 32'hFFFF_FFFF; m_score = 8'd0;
      run_eval(8'd10,  8'd13,  1'b0, 1'b1, 5'b0, -1, 1'b0);
      check_state("menu");

      // Clear every brick except bit 0, then bit 0 itself
      st = GS_LEVEL1;
      for (int b = 31; b >= 1; b--) begin
         run_eval(8'(20 * (b % 8) + 10), 8'(13 + 8 * (b / 8)), 1'b0, 1'b1, 5'b00010, b, 1'b1);
      end
      check_state("one_left");
      run_eval(8'd10,  8'd13,  1'b0, 1'b1, 5'b00010, 0, 1'b1);
      checks++;
      assert (o_cleared === 1'b1) else begin
         failures++;
         $error("FAIL cleared_level observed=%b expected=1", o_cleared);
      end

      // Score saturation at 255
      st = GS_MAIN_MENU;
      @(negedge clk);
      st = GS_LEVEL1;
      m_map = 32'hFFFF_FFFF;
      @(negedge clk);
      force dut.r_score = 8'hFF;
      @(posedge clk);
      #1;
      release dut.r_score;
      m_score = 8'hFF;
      run_eval(8'd10,  8'd13,  1'b0, 1'b1, 5'b00010, 0, 1'b1);
      check_state("saturate");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/collision_unit.md
COLLISION_UNIT -- requirements
Module: collision_unit

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, playfield width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, playfield height in pixels.
REQ-003 SHALL have parameters BRICK_W 20, BRICK_H 8, BRICK_TOP 8: brick width, brick height, first brick row y.
REQ-004 SHALL have parameters PADDLE_Y 110, PADDLE_W 24: paddle top row, paddle width.
REQ-005 clock  in  1  single clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 state  in  3  game state: mainMenu / level1 / endScreen codes.
REQ-008 tick  in  1  one-cycle pulse requesting one collision evaluation.
REQ-009 ballX, ballY  in  8 each  current ball position (unsigned).
REQ-010 dirX, dirY  in  1 each  ball direction; 1 = decreasing coordinate.
REQ-011 paddleX  in  8  paddle left edge.
REQ-012 cX, cY  out  1 each  wall/paddle bounce flags.
REQ-013 cBrickX, cBrickY  out  1 each  brick bounce flags.
REQ-014 valid  out  1  marks the cycle in which all flags are meaningful.
REQ-015 brickMap  out  32  live bricks; bit = row*8+col, 4 rows x 8 columns.
REQ-016 score  out  8  bricks destroyed this game.
REQ-017 lifeLost, cleared  out  1 each  ball passed bottom / all bricks gone.

Function
REQ-018 FSM states IDLE, PROBE, RESOLVE; IDLE->PROBE on tick while state==level1; PROBE->RESOLVE; RESOLVE->IDLE unconditionally.
REQ-019 tick outside IDLE or with state!=level1 SHALL be ignored.
REQ-020 PROBE SHALL register probe point pX=ballX±1, pY=ballY±1 per dirX/dirY, plus brick indices/hit bits of (ballX,pY) and (pX,ballY).
REQ-021 valid and all flags SHALL be one-cycle pulses in RESOLVE, i.e. 2 cycles after tick; flags 0 elsewhere.
REQ-022 cX SHALL assert when (dirX=1, ballX=0) or (dirX=0, ballX=SCREEN_W-1).
REQ-023 cY SHALL assert when (dirY=1, ballY=0) or (dirY=0, ballY+1=PADDLE_Y, paddleX<=ballX<=paddleX+PADDLE_W-1, compared at 9 bits).
REQ-024 lifeLost SHALL assert when dirY=0 and ballY=SCREEN_H-1; cY SHALL stay 0 in that case.
REQ-025 Brick region: BRICK_TOP<=y<BRICK_TOP+4*BRICK_H; col=x/BRICK_W, row=(y-BRICK_TOP)/BRICK_H, computed by compare chain, no divider.
REQ-026 If vertical probe (ballX,pY) hits a live brick: cBrickY=1, that bit cleared; else if horizontal probe (pX,ballY) hits a live brick: cBrickX=1, that bit cleared.
REQ-027 At most one brick cleared per evaluation; cBrickX and cBrickY SHALL never assert together.
REQ-028 Out-of-range probe (underflow to 255 or x>=SCREEN_W) SHALL never hit a brick.
REQ-029 score SHALL increment by 1 per cleared brick, saturating at 255.
REQ-030 cleared SHALL be a level equal to (brickMap==0).
REQ-031 Wall and brick flags MAY assert together in one RESOLVE cycle.
REQ-032 While state==mainMenu: brickMap=all ones, score=0, FSM forced to IDLE.
REQ-033 While state==endScreen: brickMap and score SHALL hold, FSM forced to IDLE.

Reset
REQ-034 reset low SHALL asynchronously force IDLE, all flags and valid to 0, brickMap to 32'hFFFF_FFFF, score to 0.
REQ-035 Reset mid-evaluation SHALL abort it; no brick cleared, no flag pulse after release.

Structure
REQ-036 Game-state codes (mainMenu=0, level1=1, endScreen=2), FSM state type and geometry defaults SHALL live in a shared game package.
REQ-037 Coordinate-to-brick-index decode SHALL be one combinational sub-module brick_locate, instantiated twice.

Verification
REQ-038 level1, ballX=0, dirX=1, ballY=60, tick -> cX=1, valid=1 two cycles later, map unchanged.
REQ-039 ballX=30, ballY=40, dirY=1 (probe y=39 -> row 3, col 1), tick -> cBrickY=1, bit 25 cleared, score=1.
REQ-040 ballY=109, dirY=0, paddleX=50, ballX=73 -> cY=1; ballX=74 -> cY=0; ballY=119 -> lifeLost=1.
REQ-041 Preload map to only bit 0 live, hit it -> cleared=1 after RESOLVE; score 255 + hit -> stays 255.
REQ-042 Assert reset in PROBE -> no valid pulse, map all ones; tick while state=mainMenu -> no valid.
